// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder with fixed LATENCY and a one-cycle MemReady strobe.
// Define DMEM_ACCESS_COUNT_EN to add saturating read/write/error access counters.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2,
   parameter int AW          = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemError,
`ifdef DMEM_ACCESS_COUNT_EN
   output logic [15:0] RdCount,
   output logic [15:0] WrCount,
   output logic [7:0]  ErrCount,
`endif
   output logic        Busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, nextState;
   logic [3:0]  cnt, cntNext;
   logic        rdQ, wrQ, errQ;
   logic [31:0] addrQ, dataQ;
   logic        curRead, curWrite, reqErr, accept, enterResp, memWe;
   logic [31:0] curAddr, curData;
   logic [AW-1:0] idx;
   logic [31:0] mem [DEPTH_WORDS];

   function automatic logic [15:0] satInc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] satInc8(input logic [7:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

   // With LATENCY=1 the accepting edge is also the RESP-entry edge, so look through to the inputs.
   always_comb begin
      curRead  = (state == IDLE) ? MemRead   : rdQ;
      curWrite = (state == IDLE) ? MemWrite  : wrQ;
      curAddr  = (state == IDLE) ? Address   : addrQ;
      curData  = (state == IDLE) ? WriteData : dataQ;
      idx      = curAddr[AW+1:2];
      reqErr   = (curRead && curWrite) || (curAddr[1:0] != 2'b00) ||
                 ((curAddr >> (AW + 2)) != 32'd0);
   end

   always_comb begin
      nextState = state;
      cntNext   = cnt;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (MemRead || MemWrite) begin
               accept    = 1'b1;
               cntNext   = 4'(LATENCY - 1);
               nextState = (LATENCY > 1) ? WAIT : RESP;
            end
         end
         WAIT: begin
            cntNext = cnt - 4'd1;
            if (cnt == 4'd1) nextState = RESP;
         end
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
      enterResp = (nextState == RESP) && (state != RESP);
      memWe     = enterResp && curWrite && !reqErr && rst_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         rdQ      <= 1'b0;
         wrQ      <= 1'b0;
         errQ     <= 1'b0;
         ReadData <= '0;
`ifdef DMEM_ACCESS_COUNT_EN
         RdCount  <= '0;
         WrCount  <= '0;
         ErrCount <= '0;
`endif
      end else begin
         state <= nextState;
         cnt   <= cntNext;
         if (accept) begin
            rdQ <= MemRead;
            wrQ <= MemWrite;
         end
         if (enterResp) begin
            errQ     <= reqErr;
            ReadData <= (curRead && !reqErr) ? mem[idx] : '0;
`ifdef DMEM_ACCESS_COUNT_EN
            if (reqErr)        ErrCount <= satInc8(ErrCount);
            else if (curRead)  RdCount  <= satInc16(RdCount);
            else if (curWrite) WrCount  <= satInc16(WrCount);
`endif
         end
      end
   end

   // Request payload and array contents are datapath only and never reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         addrQ <= Address;
         dataQ <= WriteData;
      end
      if (memWe) mem[idx] <= curData;
   end

   assign MemReady = (state == RESP);
   assign MemError = (state == RESP) && errQ;
   assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected responses, a negedge monitor checks them.
module tb_data_mem_responder;
   localparam int DEPTH = 64;
   localparam int LAT   = 2;
   localparam int AWID  = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [31:0] Address = '0, WriteData = '0;
   logic [31:0] ReadData;
   logic        MemReady, MemError, Busy;
`ifdef DMEM_ACCESS_COUNT_EN
   logic [15:0] RdCount, WrCount;
   logic [7:0]  ErrCount;
`endif

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .AW(AWID)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
      .MemReady(MemReady), .MemError(MemError),
`ifdef DMEM_ACCESS_COUNT_EN
      .RdCount(RdCount), .WrCount(WrCount), .ErrCount(ErrCount),
`endif
      .Busy(Busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sbq[$];
   int passCnt = 0;
   int totalCnt = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every response strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && MemReady) begin
         if (sbq.size() == 0) begin
            check("unexpectedReady", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            check("ReadData", ReadData, e.data);
            check("MemError", {31'd0, MemError}, {31'd0, e.err});
            check("readyCycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic waitReady();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         if (MemReady) seen = 1'b1;
      end
      if (!seen) check("readyTimeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] expData, input logic expErr);
      @(negedge clk);
      MemRead   = rd;
      MemWrite  = wr;
      Address   = addr;
      WriteData = data;
      sbq.push_back('{expData, expErr, cyc + LAT});
      waitReady();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rstReadData", ReadData, 32'd0);
      check("rstMemReady", {31'd0, MemReady}, 32'd0);
      check("rstMemError", {31'd0, MemError}, 32'd0);
      check("rstBusy", {31'd0, Busy}, 32'd0);
      rst_n = 1'b1;

      // basic write then read-back
      issue(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0);
      issue(1'b1, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0);

      // misaligned read leaves memory alone
      issue(1'b0, 1'b1, 32'h4, 32'h12345678, 32'h0, 1'b0);
      issue(1'b1, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
      issue(1'b1, 1'b0, 32'h4, 32'h0, 32'h12345678, 1'b0);

      // conflicting read+write
      issue(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
      issue(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1);
      issue(1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);

      // range boundary
      issue(1'b0, 1'b1, 32'h100, 32'h77777777, 32'h0, 1'b1);
      issue(1'b0, 1'b1, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0);
      issue(1'b1, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0);
      issue(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
      issue(1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);

      // back-to-back writes with MemWrite held high
      @(negedge clk);
      MemWrite  = 1'b1;
      Address   = 32'h0;
      WriteData = 32'h100;
      sbq.push_back('{32'h0, 1'b0, cyc + LAT});
      for (int k = 1; k < 3; k++) begin
         repeat (LAT) @(negedge clk);
         Address   = 32'(4 * k);
         WriteData = 32'(256 * (k + 1));
         sbq.push_back('{32'h0, 1'b0, cyc + LAT + 1});
         @(negedge clk);
      end
      repeat (LAT) @(negedge clk);
      MemWrite = 1'b0;
      issue(1'b1, 1'b0, 32'h0, 32'h0, 32'h100, 1'b0);
      issue(1'b1, 1'b0, 32'h4, 32'h0, 32'h200, 1'b0);
      issue(1'b1, 1'b0, 32'h8, 32'h0, 32'h300, 1'b0);

      // reset during WAIT of a write drops it
      issue(1'b0, 1'b1, 32'h10, 32'h11112222, 32'h0, 1'b0);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 32'h11112222, 1'b0);
      @(negedge clk);
      MemWrite  = 1'b1;
      Address   = 32'h10;
      WriteData = 32'h99999999;
      @(negedge clk);
      MemWrite = 1'b0;
      check("busyInWait", {31'd0, Busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abortBusy", {31'd0, Busy}, 32'd0);
      check("abortMemReady", {31'd0, MemReady}, 32'd0);
      check("abortMemError", {31'd0, MemError}, 32'd0);
      check("abortReadData", ReadData, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
`ifdef DMEM_ACCESS_COUNT_EN
      check("rstRdCount", {16'd0, RdCount}, 32'd0);
      check("rstWrCount", {16'd0, WrCount}, 32'd0);
      check("rstErrCount", {24'd0, ErrCount}, 32'd0);
`endif
      issue(1'b1, 1'b0, 32'h10, 32'h0, 32'h11112222, 1'b0);
      issue(1'b0, 1'b1, 32'h14, 32'h5, 32'h0, 1'b0);
      issue(1'b1, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1);
`ifdef DMEM_ACCESS_COUNT_EN
      check("RdCount", {16'd0, RdCount}, 32'd1);
      check("WrCount", {16'd0, WrCount}, 32'd1);
      check("ErrCount", {24'd0, ErrCount}, 32'd1);
`endif
      issue(1'b1, 1'b0, 32'h14, 32'h0, 32'h5, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboardDrained", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end
endmodule
